// File: rtl/lcd_read_cycle_if.sv
// ----------------------------------------------------------------------------
// lcd_read_cycle_if
// Bundles the request handshake and the HD44780 read-side pins of
// lcd_read_cycle.
//   master : the requester (drives rd_enable/reg_sel/poll_bf, presents db_in)
//   slave  : the read-cycle engine (drives LCD pins, rd_data and status)
// Signals:
//   rd_enable, reg_sel, poll_bf  request and its options
//   db_in[7:0]                   LCD data bus as seen by the FPGA
//   rs_out, rw_out, e_out        LCD control pins
//   db_oe                        1 = FPGA may drive db, 0 = bus released
//   rd_data[7:0]                 last sampled byte
//   busy, rd_finish, timeout     status
// ----------------------------------------------------------------------------
interface lcd_read_cycle_if;
    logic       rd_enable;
    logic       reg_sel;
    logic       poll_bf;
    logic [7:0] db_in;
    logic       rs_out;
    logic       rw_out;
    logic       e_out;
    logic       db_oe;
    logic [7:0] rd_data;
    logic       busy;
    logic       rd_finish;
    logic       timeout;

    modport master (
        output rd_enable, reg_sel, poll_bf, db_in,
        input  rs_out, rw_out, e_out, db_oe, rd_data, busy, rd_finish, timeout
    );

    modport slave (
        input  rd_enable, reg_sel, poll_bf, db_in,
        output rs_out, rw_out, e_out, db_oe, rd_data, busy, rd_finish, timeout
    );
endinterface

// File: rtl/lcd_read_cycle.sv
// ----------------------------------------------------------------------------
// lcd_read_cycle
// HD44780-style read-cycle engine. It performs one read of BF/AC (RS=0) or of
// DDRAM/CGRAM data (RS=1). It can also keep polling the busy flag until it
// clears. Every output is registered.
// Ports:
//   clk   slow LCD clock
//   rst   synchronous reset, active-high
//   bus   lcd_read_cycle_if.slave (request, LCD pins, rd_data, status)
// Parameters: SETUP_CYC, E_HIGH_CYC, HOLD_CYC (1..15), POLL_MAX (1..255).
// Build option: define LCD_BF_TIMEOUT_EN to bound polling to POLL_MAX reads
// and report a timeout. Without it, polling runs until BF clears, timeout is
// tied low and POLL_MAX is ignored.
// ----------------------------------------------------------------------------
module lcd_read_cycle #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned E_HIGH_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned POLL_MAX   = 255
) (
    input logic             clk,
    input logic             rst,
    lcd_read_cycle_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StSetup, StEHi, StHold, StDone} state_e;

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;         // phase counter, counts down to 0
    logic       rs_lat_q, rs_lat_d;
    logic       poll_q, poll_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       timeout_q, timeout_d;
    logic       rs_q, rs_d;
    logic       rw_q, rw_d;
    logic       e_q, e_d;
    logic       busy_q, busy_d;
    logic       fin_q, fin_d;
    logic       again;                // HOLD ends with another BF read

`ifdef LCD_BF_TIMEOUT_EN
    logic [7:0] poll_cnt_q, poll_cnt_d;
    logic [8:0] poll_next;

    // Evaluated 9 bits wide, so the 8-bit counter can never wrap.
    assign poll_next = {1'b0, poll_cnt_q} + 9'd1;
    assign again     = poll_q & rd_data_q[7] & (poll_next < 9'(POLL_MAX));
`else
    logic [7:0] unused_poll_max;

    assign unused_poll_max = 8'(POLL_MAX);
    assign again           = poll_q & rd_data_q[7];
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rs_lat_d  = rs_lat_q;
        poll_d    = poll_q;
        rd_data_d = rd_data_q;
        timeout_d = timeout_q;
`ifdef LCD_BF_TIMEOUT_EN
        poll_cnt_d = poll_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.rd_enable) begin
                    state_d   = StSetup;
                    cnt_d     = 4'(SETUP_CYC - 1);
                    // A busy-flag poll always targets the instruction register.
                    rs_lat_d  = bus.poll_bf ? 1'b0 : bus.reg_sel;
                    poll_d    = bus.poll_bf;
                    timeout_d = 1'b0;
`ifdef LCD_BF_TIMEOUT_EN
                    poll_cnt_d = 8'd0;
`endif
                end
            end
            StSetup: begin
                if (cnt_q == 4'd0) begin
                    state_d = StEHi;
                    cnt_d   = 4'(E_HIGH_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StEHi: begin
                if (cnt_q == 4'd0) begin
                    state_d   = StHold;
                    cnt_d     = 4'(HOLD_CYC - 1);
                    rd_data_d = bus.db_in;   // sampled on the last E-high edge
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHold: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (again) begin
                    state_d = StSetup;
                    cnt_d   = 4'(SETUP_CYC - 1);
`ifdef LCD_BF_TIMEOUT_EN
                    poll_cnt_d = poll_next[7:0];
`endif
                end else begin
                    state_d = StDone;
`ifdef LCD_BF_TIMEOUT_EN
                    // Registered here, so it is already valid alongside rd_finish.
                    timeout_d = poll_q & rd_data_q[7];
`endif
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Moore outputs are decoded from the next state and then registered.
        busy_d = (state_d != StIdle);
        rw_d   = (state_d == StSetup) || (state_d == StEHi) || (state_d == StHold);
        e_d    = (state_d == StEHi);
        fin_d  = (state_d == StDone);
        rs_d   = rw_d & rs_lat_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            rs_lat_q  <= 1'b0;
            poll_q    <= 1'b0;
            rd_data_q <= 8'h00;
            timeout_q <= 1'b0;
            rs_q      <= 1'b0;
            rw_q      <= 1'b0;
            e_q       <= 1'b0;
            busy_q    <= 1'b0;
            fin_q     <= 1'b0;
`ifdef LCD_BF_TIMEOUT_EN
            poll_cnt_q <= 8'd0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rs_lat_q  <= rs_lat_d;
            poll_q    <= poll_d;
            rd_data_q <= rd_data_d;
            timeout_q <= timeout_d;
            rs_q      <= rs_d;
            rw_q      <= rw_d;
            e_q       <= e_d;
            busy_q    <= busy_d;
            fin_q     <= fin_d;
`ifdef LCD_BF_TIMEOUT_EN
            poll_cnt_q <= poll_cnt_d;
`endif
        end
    end

    assign bus.rs_out    = rs_q;
    assign bus.rw_out    = rw_q;
    assign bus.e_out     = e_q;
    assign bus.db_oe     = ~rw_q;    // the bus is released for the whole read
    assign bus.rd_data   = rd_data_q;
    assign bus.busy      = busy_q;
    assign bus.rd_finish = fin_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_lcd_read_cycle.sv
module tb_lcd_read_cycle;

    localparam int S  = 1;
    localparam int EH = 2;
    localparam int H  = 1;
    localparam int P  = S + EH + H;
    localparam int PM = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    lcd_read_cycle_if bus();

    lcd_read_cycle #(
        .SETUP_CYC (S),
        .E_HIGH_CYC(EH),
        .HOLD_CYC  (H),
        .POLL_MAX  (PM)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic           rsel;
        logic           pbf;
        logic [5:0][7:0] b;      // byte returned by read n is b[n]
        logic [3:0]     reads;
        logic [7:0]     data;
        logic           to;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the number of reads follows from the BF rule alone.
    function automatic void model(input logic pbf, input logic [5:0][7:0] b,
                                  output int n, output logic [7:0] d, output logic to);
        n  = 0;
        d  = 8'h00;
        to = 1'b0;
        for (int i = 0; i < 6; i++) begin
            d = b[i];
            n = i + 1;
            if (!(pbf && d[7])) break;
`ifdef LCD_BF_TIMEOUT_EN
            if (n >= PM) begin
                to = 1'b1;
                break;
            end
`endif
        end
    endfunction

    // Applies one request before the accept edge and checks every cycle until
    // the IDLE cycle after DONE. mode 0: quiet inputs, 1: random noise on the
    // request inputs, 2: rd_enable held high and reg_sel forced to 0 throughout.
    task automatic run_txn(input logic rsel, input logic pbf, input logic [5:0][7:0] b,
                           input int n, input logic [7:0] d, input logic to,
                           input int mode, input string tag);
        int   fin;
        int   r;
        logic rs_exp;
        logic e_exp;
        fin    = 1 + n * P;
        rs_exp = pbf ? 1'b0 : rsel;
        bus.rd_enable = 1'b1;
        bus.reg_sel   = rsel;
        bus.poll_bf   = pbf;
        bus.db_in     = b[0];
        for (int c = 1; c <= fin; c++) begin
            tick();
            if (c == fin) begin
                chk($sformatf("%s c%0d finish", tag, c), 32'(bus.rd_finish), 32'd1);
                chk($sformatf("%s c%0d rw", tag, c), 32'(bus.rw_out), 32'd0);
                chk($sformatf("%s c%0d oe", tag, c), 32'(bus.db_oe), 32'd1);
                chk($sformatf("%s c%0d e", tag, c), 32'(bus.e_out), 32'd0);
                chk($sformatf("%s c%0d busy", tag, c), 32'(bus.busy), 32'd1);
                chk($sformatf("%s rd_data", tag), 32'(bus.rd_data), 32'(d));
                chk($sformatf("%s timeout", tag), 32'(bus.timeout), 32'(to));
            end else begin
                e_exp = (((c - 1) % P) >= S) && (((c - 1) % P) < S + EH);
                chk($sformatf("%s c%0d e", tag, c), 32'(bus.e_out), 32'(e_exp));
                chk($sformatf("%s c%0d rw", tag, c), 32'(bus.rw_out), 32'd1);
                chk($sformatf("%s c%0d rs", tag, c), 32'(bus.rs_out), 32'(rs_exp));
                chk($sformatf("%s c%0d oe", tag, c), 32'(bus.db_oe), 32'd0);
                chk($sformatf("%s c%0d busy", tag, c), 32'(bus.busy), 32'd1);
                chk($sformatf("%s c%0d finish", tag, c), 32'(bus.rd_finish), 32'd0);
                chk($sformatf("%s c%0d timeout", tag, c), 32'(bus.timeout), 32'd0);
            end
            // Inputs for the edge that ends cycle c.
            r = (c - 1) / P;
            bus.db_in = (r < 6) ? b[r] : 8'h00;
            if (mode == 1) begin
                bus.rd_enable = 1'($urandom);
                bus.reg_sel   = 1'($urandom);
                bus.poll_bf   = 1'($urandom);
            end else if (mode == 2) begin
                bus.rd_enable = 1'b1;
                bus.reg_sel   = 1'b0;
                bus.poll_bf   = 1'b0;
            end else begin
                bus.rd_enable = 1'b0;
            end
        end
        tick();
        chk($sformatf("%s idle busy", tag), 32'(bus.busy), 32'd0);
        chk($sformatf("%s idle finish", tag), 32'(bus.rd_finish), 32'd0);
        chk($sformatf("%s idle oe", tag), 32'(bus.db_oe), 32'd1);
        chk($sformatf("%s idle rs", tag), 32'(bus.rs_out), 32'd0);
        chk($sformatf("%s idle rd_data", tag), 32'(bus.rd_data), 32'(d));
        chk($sformatf("%s idle timeout", tag), 32'(bus.timeout), 32'(to));
        if (mode != 2) bus.rd_enable = 1'b0;
    endtask

    vec_t vec [4];

    initial begin
        int        n;
        logic [7:0] d;
        logic      to;
        logic [5:0][7:0] b;

        vec[0] = '{rsel: 1'b1, pbf: 1'b0, b: 48'h00_00_00_00_00_5A,
                   reads: 4'd1, data: 8'h5A, to: 1'b0};
        vec[1] = '{rsel: 1'b0, pbf: 1'b0, b: 48'h00_00_00_00_00_80,
                   reads: 4'd1, data: 8'h80, to: 1'b0};
        vec[2] = '{rsel: 1'b1, pbf: 1'b1, b: 48'h07_07_07_80_80_80,
                   reads: 4'd4, data: 8'h07, to: 1'b0};
`ifdef LCD_BF_TIMEOUT_EN
        vec[3] = '{rsel: 1'b1, pbf: 1'b1, b: 48'hFF_FF_FF_FF_FF_FF,
                   reads: 4'd4, data: 8'hFF, to: 1'b1};
`else
        vec[3] = '{rsel: 1'b1, pbf: 1'b1, b: 48'h7F_FF_FF_FF_FF_FF,
                   reads: 4'd6, data: 8'h7F, to: 1'b0};
`endif

        bus.rd_enable = 1'b0;
        bus.reg_sel   = 1'b0;
        bus.poll_bf   = 1'b0;
        bus.db_in     = 8'h00;

        // Reset, then 20 idle cycles with no E pulse.
        tick();
        tick();
        rst = 1'b0;
        chk("reset rs", 32'(bus.rs_out), 32'd0);
        chk("reset rw", 32'(bus.rw_out), 32'd0);
        chk("reset oe", 32'(bus.db_oe), 32'd1);
        chk("reset rd_data", 32'(bus.rd_data), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset finish", 32'(bus.rd_finish), 32'd0);
        chk("reset timeout", 32'(bus.timeout), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("idle%0d e", i), 32'(bus.e_out), 32'd0);
            chk($sformatf("idle%0d busy", i), 32'(bus.busy), 32'd0);
        end

        // Directed vectors.
        for (int i = 0; i < 4; i++) begin
            run_txn(vec[i].rsel, vec[i].pbf, vec[i].b, int'(vec[i].reads), vec[i].data,
                    vec[i].to, 0, $sformatf("vec%0d", i));
        end

        // rd_enable held high through the cycle and DONE: the following IDLE
        // cycle accepts the new request with reg_sel=0.
        run_txn(1'b1, 1'b0, 48'h11_11_11_11_11_A5, 1, 8'hA5, 1'b0, 2, "hold1");
        run_txn(1'b0, 1'b0, 48'h22_22_22_22_22_3C, 1, 8'h3C, 1'b0, 0, "hold2");

        // Reset during E_HI aborts immediately, with no rd_finish.
        bus.rd_enable = 1'b1;
        bus.reg_sel   = 1'b1;
        bus.poll_bf   = 1'b0;
        tick();
        bus.rd_enable = 1'b0;
        tick();
        chk("abort e_hi", 32'(bus.e_out), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort e", 32'(bus.e_out), 32'd0);
        chk("abort rw", 32'(bus.rw_out), 32'd0);
        chk("abort oe", 32'(bus.db_oe), 32'd1);
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort rd_data", 32'(bus.rd_data), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("abort%0d finish", i), 32'(bus.rd_finish), 32'd0);
            chk($sformatf("abort%0d busy", i), 32'(bus.busy), 32'd0);
        end

        // Randomized requests with noisy inputs while busy.
        for (int t = 0; t < 40; t++) begin
            logic rs_r;
            logic pb_r;
            rs_r = 1'($urandom);
            pb_r = 1'($urandom);
            for (int k = 0; k < 6; k++) begin
                b[k] = 8'($urandom);
                b[k][7] = ($urandom_range(3, 0) != 0);
            end
            b[5][7] = 1'b0;
            model(pb_r, b, n, d, to);
            run_txn(rs_r, pb_r, b, n, d, to, 1, $sformatf("rnd%0d", t));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
